// File: rtl/ssd_debug_scanner_pkg.sv
// Shared seven-segment constants, debouncer states and the hex decoder.
package ssd_debug_scanner_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        DB_IDLE,
        DB_PRESS_WAIT,
        DB_HELD,
        DB_RELEASE_WAIT
    } db_state_t;

    // Active-low segments ordered {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ssd_debug_scanner_step_debouncer.sv
// Step button conditioner: 2-flop synchroniser, press/release
// debounce FSM and a single-cycle pulse per accepted press.
module step_debouncer
    import ssd_debug_scanner_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYC - 1);

    logic            s1;
    logic            s2;
    logic [CW-1:0]   cnt;
    db_state_t       st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            st    <= DB_IDLE;
            pulse <= 1'b0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            pulse <= 1'b0;
            unique case (st)
                DB_IDLE: begin
                    if (s2) begin
                        st  <= DB_PRESS_WAIT;
                        cnt <= '0;
                    end
                end
                DB_PRESS_WAIT: begin
                    if (!s2) begin
                        st <= DB_IDLE;
                    end else if (cnt == TERM) begin
                        st    <= DB_HELD;
                        pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DB_HELD: begin
                    if (!s2) begin
                        st  <= DB_RELEASE_WAIT;
                        cnt <= '0;
                    end
                end
                DB_RELEASE_WAIT: begin
                    // A bounce back high re-enters HELD, never re-arms
                    if (s2) begin
                        st <= DB_HELD;
                    end else if (cnt == TERM) begin
                        st <= DB_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: st <= DB_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ssd_debug_scanner.sv
// Board-debug front end: step button conditioning plus a multiplexed
// seven-segment view of a selectable probe channel nibble window.
module ssd_debug_scanner
    import ssd_debug_scanner_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int NUM_CH       = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int LEAD_BLANK   = 0
) (
    input  logic                  clk50M,
    input  logic                  rst,
    input  logic                  step_btn,
    output logic                  step_pulse,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ch_sel,
    input  logic [2:0]            win_sel,
    input  logic [32*NUM_CH-1:0]  probe_data,
    output logic [6:0]            C,
    output logic [DIGITS-1:0]     AN
);

    localparam int CSW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int W   = 4 * DIGITS;
    localparam int RW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [RW-1:0] R_TERM = RW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);

    logic [RW-1:0]     rcnt;
    logic [IW-1:0]     idx;
    logic [W-1:0]      snap;
    logic              snap_bad;
    logic [31:0]       chan;
    logic              sel_bad;
    logic [7:0]        sh;
    logic [W-1:0]      win;
    logic [W-1:0]      shd;
    logic              blank;
    logic [6:0]        seg_nxt;
    logic [DIGITS-1:0] an_nxt;

    step_debouncer #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_db (
        .clk   (clk50M),
        .rst   (rst),
        .btn   (step_btn),
        .pulse (step_pulse)
    );

    always_comb begin
        chan = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_sel == CSW'(k)) chan = probe_data[32*k +: 32];
        end
        sel_bad = int'(ch_sel) >= NUM_CH;
        sh      = 8'(win_sel) * 8'(W);
        win     = (sh >= 8'd32) ? '0 : W'(chan >> sh);
    end

    // Current digit and everything above it sit in the low bits of shd
    always_comb begin
        shd     = snap >> {idx, 2'b00};
        blank   = (LEAD_BLANK != 0) && (idx != '0) && (shd == '0);
        seg_nxt = snap_bad ? SEG_DASH :
                  blank    ? SEG_BLANK : hex2seg(shd[3:0]);
        an_nxt  = ~(DIGITS'(1) << idx);
    end

    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            rcnt     <= '0;
            idx      <= '0;
            snap     <= '0;
            snap_bad <= 1'b0;
            AN       <= '1;
            C        <= SEG_BLANK;
        end else begin
            AN <= an_nxt;
            C  <= seg_nxt;
            if (rcnt == R_TERM) begin
                rcnt <= '0;
                if (idx == I_LAST) begin
                    idx      <= '0;
                    snap     <= win;
                    snap_bad <= sel_bad;
                end else begin
                    idx <= idx + 1'b1;
                end
            end else begin
                rcnt <= rcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ssd_debug_scanner.sv
// Scoreboard bench: two scanner builds (4 ch plain, 3 ch lead-blank)
// driven by random frames and button episodes against a reference model.
module tb_ssd_debug_scanner;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] c;
    } dig_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         btn;
    logic [1:0]   cs;
    logic [2:0]   ws;
    logic [127:0] pd;
    logic         p4, p3;
    logic [6:0]   c4, c3;
    logic [3:0]   an4, an3;

    int compared   = 0;
    int mismatched = 0;

    dig_t q4[$];
    dig_t q3[$];
    int   qp4[$];
    int   qp3[$];
    int   ep = 0;
    bit   mon_en = 1'b0;

    logic [6:0] segtab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    always #5 clk = ~clk;

    ssd_debug_scanner #(
        .DIGITS(4), .NUM_CH(4), .REFRESH_DIV(4),
        .DEBOUNCE_CYC(8), .LEAD_BLANK(0)
    ) dut4 (
        .clk50M(clk), .rst(rst), .step_btn(btn),
        .step_pulse(p4), .ch_sel(cs), .win_sel(ws),
        .probe_data(pd), .C(c4), .AN(an4)
    );

    ssd_debug_scanner #(
        .DIGITS(4), .NUM_CH(3), .REFRESH_DIV(4),
        .DEBOUNCE_CYC(8), .LEAD_BLANK(1)
    ) dut3 (
        .clk50M(clk), .rst(rst), .step_btn(btn),
        .step_pulse(p3), .ch_sel(cs), .win_sel(ws),
        .probe_data(pd[95:0]), .C(c3), .AN(an3)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Expected segments of digit d for a frame built from these inputs
    function automatic logic [6:0] ref_seg(input logic [127:0] p,
            input int c, input int w, input int nch,
            input bit lb, input int d);
        logic [31:0] v;
        logic [15:0] win;
        int          msd;
        logic [3:0]  nib;
        if (c >= nch) return 7'b0111111;
        v   = p[32*c +: 32];
        win = (w * 16 >= 32) ? 16'h0 : 16'(v / (64'd1 << (w * 16)));
        msd = 0;
        for (int i = 0; i < 4; i++)
            if (((win >> (4 * i)) & 16'hF) != 0) msd = i;
        nib = 4'((win >> (4 * d)) & 16'hF);
        if (lb && d > msd) return 7'h7F;
        return segtab[nib];
    endfunction

    task automatic push_frame(input logic [127:0] p, input int c,
                              input int w);
        for (int d = 0; d < 4; d++) begin
            q4.push_back({4'(~(32'd1 << d)), ref_seg(p, c, w, 4, 0, d)});
            q3.push_back({4'(~(32'd1 << d)), ref_seg(p, c, w, 3, 1, d)});
        end
    endtask

    // Display monitor: a new AN value means a new digit is presented
    logic [3:0] prev4 = 4'hF;
    logic [3:0] prev3 = 4'hF;
    dig_t cur4, cur3;
    bit   have4 = 0, have3 = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (an4 !== prev4) begin
                chk("q4_has_entry", q4.size() != 0, 1);
                if (q4.size() != 0) begin
                    cur4  = q4.pop_front();
                    have4 = 1;
                end
            end
            if (an3 !== prev3) begin
                chk("q3_has_entry", q3.size() != 0, 1);
                if (q3.size() != 0) begin
                    cur3  = q3.pop_front();
                    have3 = 1;
                end
            end
            if (have4) begin
                chk("an4", an4, cur4.an);
                chk("c4", c4, cur4.c);
            end
            if (have3) begin
                chk("an3", an3, cur3.an);
                chk("c3", c3, cur3.c);
            end
        end else begin
            have4 = 0;
            have3 = 0;
        end
        prev4 = an4;
        prev3 = an3;
    end

    // Pulse monitor: every pulse must match a press episode, 1 cycle wide
    logic pp4 = 1'b0, pp3 = 1'b0;
    always @(negedge clk) begin
        int e;
        if (p4) begin
            chk("pulse4_width", pp4, 0);
            e = (qp4.size() != 0) ? qp4.pop_front() : -1;
            chk("pulse4_episode", ep, e);
        end
        if (p3) begin
            chk("pulse3_width", pp3, 0);
            e = (qp3.size() != 0) ? qp3.pop_front() : -1;
            chk("pulse3_episode", ep, e);
        end
        pp4 = p4;
        pp3 = p3;
    end

    task automatic reset_restart();
        mon_en = 0;
        rst    = 1;
        #1;
        chk("rst_an4", an4, 4'hF);
        chk("rst_c4", c4, 7'h7F);
        chk("rst_an3", an3, 4'hF);
        chk("rst_c3", c3, 7'h7F);
        chk("rst_pulse4", p4, 0);
        repeat (2) @(negedge clk);
        q4.delete();
        q3.delete();
        push_frame('0, 0, 0);
        mon_en = 1;
        rst    = 0;
    endtask

    // One 16-cycle frame; the final values are snapshotted at its end
    task automatic frame(input logic [127:0] p, input int c,
                         input int w, input bit mid);
        int j1, j2;
        j1 = $urandom_range(0, 6);
        j2 = $urandom_range(7, 14);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (mid && i == j1) begin
                pd = {$urandom, $urandom, $urandom, $urandom};
                cs = 2'($urandom);
                ws = 3'($urandom);
            end
            if (i == j2) begin
                pd = p;
                cs = 2'(c);
                ws = 3'(w);
            end
        end
        push_frame(p, c, w);
    endtask

    task automatic rand_frame();
        logic [127:0] p;
        for (int k = 0; k < 4; k++)
            p[32*k +: 32] = $urandom >> $urandom_range(0, 31);
        frame(p, $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0) ? $urandom_range(2, 7)
                                          : $urandom_range(0, 1),
              1'($urandom));
    endtask

    task automatic episode(input bit press, input int ng,
                           input int gl, input int hold);
        ep++;
        if (press) begin
            qp4.push_back(ep);
            qp3.push_back(ep);
        end
        repeat (ng) begin
            btn = 1;
            repeat (gl > 0 ? gl : $urandom_range(1, 3)) @(negedge clk);
            btn = 0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        if (press) begin
            btn = 1;
            repeat (hold) @(negedge clk);
            repeat (4) begin
                btn = 0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                btn = 1;
                @(negedge clk);
            end
            btn = 0;
        end
        repeat (14) @(negedge clk);
    endtask

    logic [127:0] pdir;

    initial begin
        rst  = 1;
        btn  = 0;
        cs   = 0;
        ws   = 0;
        pd   = '0;
        pdir = {32'hDEADBEEF, 32'h0, 32'h1234ABCD, 32'h00000050};
        reset_restart();

        frame(pdir, 1, 0, 0);
        frame(pdir, 1, 1, 1);
        frame(pdir, 0, 0, 1);
        frame(pdir, 2, 0, 0);
        frame(pdir, 3, 0, 1);
        frame(pdir, 1, 2, 0);
        frame(pdir, 3, 1, 0);
        repeat (20) rand_frame();

        repeat ($urandom_range(3, 10)) @(negedge clk);
        reset_restart();
        repeat (8) rand_frame();
        repeat (15) @(negedge clk);
        chk("q4_drained", q4.size(), 0);
        chk("q3_drained", q3.size(), 0);
        mon_en = 0;

        episode(1, 3, 3, 20);
        episode(0, 4, 3, 0);
        for (int i = 0; i < 20; i++)
            episode(1'($urandom), $urandom_range(0, 3), 0,
                    $urandom_range(12, 30));

        ep++;
        btn = 1;
        repeat (6) @(negedge clk);
        rst = 1;
        btn = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (20) @(negedge clk);

        chk("pulses4_left", qp4.size(), 0);
        chk("pulses3_left", qp3.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
